instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch sequencer: producer side of the instruction-register load interface (drives ins/ir_ld).
//  Holds PC, issues one read per fetch_req to instruction memory, waits for the response,
//  then presents the word on ins with a one-cycle ir_ld pulse and advances PC.
//  Sits between the control FSM (fetch_req, pc_ld) and instruction ROM/RAM.
// PARAMETERS
//  IW          12     instruction width; equals the IR width
//  AW          8      PC / memory address width
//  HALT_OPCODE 4'hF   opcode in ins[IW-1:IW-4] treated as HALT (used only with FETCH_HALT_EN)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high
//  fetch_req  in   1   control requests next instruction; sampled only in IDLE
//  pc_ld      in   1   load PC from pc_in (jump/branch); accepted in every state
//  pc_in      in   AW  jump target
//  mem_rd     out  1   read strobe, high exactly one cycle per fetch (ISSUE state)
//  mem_addr   out  AW  read address; equals pc while mem_rd=1
//  mem_data   in   IW  read data, valid when mem_valid=1
//  mem_valid  in   1   read response; latency >=1 cycle after mem_rd, sampled in WAIT/DROP only
//  ins        out  IW  fetched instruction to IR; stable from LOAD until next LOAD
//  ir_ld      out  1   one-cycle IR load pulse, coincident with new ins
//  busy       out  1   high whenever state != IDLE
//  pc         out  AW  current program counter
//  halted     out  1   HALT seen; constant 0 without FETCH_HALT_EN
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, ins=0, ir_ld=0, mem_rd=0, busy=0, halted=0.
//  FSM IDLE/ISSUE/WAIT/LOAD/DROP; all outputs registered or decoded from state only.
//  IDLE : fetch_req -> ISSUE. pc_ld in same cycle: pc<=pc_in, fetch then uses pc_in.
//  ISSUE: mem_rd=1, mem_addr=pc -> WAIT. pc_ld here -> pc<=pc_in, go DROP (read in flight).
//  WAIT : mem_valid -> ins<=mem_data, go LOAD. pc_ld -> pc<=pc_in, go DROP; if mem_valid in
//         the same cycle the data is discarded and state goes IDLE (no ir_ld).
//  LOAD : ir_ld=1 for this cycle only; pc<=pc+1 (wraps 2^AW-1 -> 0); -> IDLE.
//         pc_ld in LOAD: ir_ld still asserted, pc<=pc_in instead of pc+1.
//  DROP : wait for mem_valid, discard data, -> IDLE; ir_ld never asserted; pc_ld updates pc.
//  Latency, 1-cycle memory: fetch_req @n -> mem_rd @n+1 -> mem_valid @n+2 -> ir_ld @n+3,
//  IDLE @n+4. fetch_req outside IDLE is ignored (control must wait for !busy).
//  At most one read outstanding; mem_valid outside WAIT/DROP is ignored.
//  Reset mid-fetch: immediate return to reset state; late mem_valid ignored in IDLE.
// CONFIGURATION
//  FETCH_HALT_EN defined: in LOAD, if mem word opcode == HALT_OPCODE: ir_ld still pulses,
//   halted<=1, pc NOT incremented; while halted, fetch_req ignored; cleared by reset or pc_ld.
//  FETCH_HALT_EN undefined: halted tied 0; HALT_OPCODE fetched like any other instruction.
// STRUCTURE
//  Package fetch_pkg: fetch_state_t enum (IDLE,ISSUE,WAIT,LOAD,DROP), default IW/AW,
//   HALT_OPCODE localparam.
//  Sub-module pc_counter: AW-bit register with synchronous reset, load (priority), increment.
//  FSM, ins register and halt flag stay in instr_fetch.
// TESTING
//  1) Reset, mem latency 1, fetch_req @0 -> mem_rd @1 addr 0, ir_ld @3 ins=mem[0], pc=1.
//  2) Three back-to-back fetches, latency 3 -> ins=mem[0..2] in order, one ir_ld each, pc=3.
//  3) pc=8'hFF, fetch -> ir_ld with mem[FF], pc wraps to 8'h00.
//  4) pc_ld pc_in=8'h40 during WAIT, late mem_valid -> no ir_ld, pc=8'h40; next fetch reads 0x40.
//  5) pc_ld 8'h20 with fetch_req in IDLE -> mem_addr=8'h20; pc_ld during LOAD -> ir_ld, pc=pc_in.
//  6) FETCH_HALT_EN, mem[5]=12'hF00 -> halted=1, pc stays 5, fetch_req ignored; pc_ld clears.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch sequencer
package fetch_pkg;

    localparam int IW_DEF = 12;
    localparam int AW_DEF = 8;
    localparam logic [3:0] HALT_OPCODE = 4'hF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        LOAD  = 3'd3,
        DROP  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory read port between fetch sequencer and ROM/RAM
interface instr_fetch_if #(
    parameter int IW = 12,
    parameter int AW = 8
);
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_data;
    logic          mem_valid;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_data,
        input  mem_valid
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_data,
        output mem_valid
    );
endinterface

// File: rtl/instr_fetch_pc_counter.sv
// rtl/instr_fetch_pc_counter.sv - program counter register: load has priority over increment
module pc_counter #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          inc,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] q
);

    // Increment wraps naturally from all-ones back to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (inc) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch sequencer: PC, single outstanding memory read, IR load pulse
// Optional HALT opcode detection is enabled with FETCH_HALT_EN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int         IW          = IW_DEF,
    parameter int         AW          = AW_DEF,
    parameter logic [3:0] HALT_OPCODE = fetch_pkg::HALT_OPCODE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic                 pc_ld,
    input  logic [AW-1:0]        pc_in,
    instr_fetch_if.master        mem,
    output logic [IW-1:0]        ins,
    output logic                 ir_ld,
    output logic                 busy,
    output logic [AW-1:0]        pc,
    output logic                 halted
);

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic         halt_hit;
    logic         pc_inc;
    logic         halted_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A jump while a read is in flight must still absorb that response (DROP),
    // unless the response arrives in the very same cycle as the jump.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fetch_req && !halted_q) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = pc_ld ? DROP : WAIT;
            end
            WAIT: begin
                if (pc_ld) begin
                    state_nxt = mem.mem_valid ? IDLE : DROP;
                end else if (mem.mem_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = IDLE;
            end
            DROP: begin
                if (mem.mem_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ins <= '0;
        end else if (state == WAIT && mem.mem_valid && !pc_ld) begin
            ins <= mem.mem_data;
        end
    end

    // ins already holds the fetched word while in LOAD, so the opcode is taken from it.
    assign halt_hit = HALT_EN && (state == LOAD) && (ins[IW-1 -: 4] == HALT_OPCODE);
    assign pc_inc   = (state == LOAD) && !halt_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else if (pc_ld) begin
            halted_q <= 1'b0;
        end else if (halt_hit) begin
            halted_q <= 1'b1;
        end
    end

    pc_counter #(
        .AW(AW)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .load  (pc_ld),
        .inc   (pc_inc),
        .d     (pc_in),
        .q     (pc)
    );

    assign mem.mem_rd   = (state == ISSUE);
    assign mem.mem_addr = pc;
    assign ir_ld        = (state == LOAD);
    assign busy         = (state != IDLE);
    assign halted       = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with a transaction-level reference model
module tb_instr_fetch;

`ifdef FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic        pc_ld;
    logic [7:0]  pc_in;
    logic [11:0] ins;
    logic        ir_ld;
    logic        busy;
    logic [7:0]  pc;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch_if #(.IW(12), .AW(8)) mif ();

    instr_fetch #(.IW(12), .AW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_req (fetch_req),
        .pc_ld     (pc_ld),
        .pc_in     (pc_in),
        .mem       (mif.master),
        .ins       (ins),
        .ir_ld     (ir_ld),
        .busy      (busy),
        .pc        (pc),
        .halted    (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory with programmable response latency (cycles after the mem_rd cycle).
    logic [11:0] mem [256];
    int          lat = 1;
    int          resp_cnt = 0;
    logic [7:0]  raddr = 8'h00;

    always @(posedge clk) begin
        #1;
        mif.mem_valid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mif.mem_valid = 1'b1;
                mif.mem_data  = mem[raddr];
            end
        end
        if (mif.mem_rd === 1'b1) begin
            raddr    = mif.mem_addr;
            resp_cnt = lat;
        end
    end

    // Reference model: an accepted request reads the current (or same-cycle jump) PC
    // one cycle later; a completed load presents that word and advances PC unless it
    // is a HALT; a jump always overrides PC and clears halt.
    logic [7:0]  m_pc = 8'h00;
    logic [11:0] m_ins = 12'h000;
    bit          m_halt = 1'b0;
    bit          exp_rd = 1'b0;
    logic [7:0]  exp_addr = 8'h00;
    logic [7:0]  last_addr = 8'h00;
    int          ir_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            m_pc   = 8'h00;
            m_ins  = 12'h000;
            m_halt = 1'b0;
            exp_rd = 1'b0;
        end else begin
            chk("mem_rd", 32'(mif.mem_rd), 32'(exp_rd));
            if (exp_rd) begin
                chk("mem_addr", 32'(mif.mem_addr), 32'(exp_addr));
                last_addr = exp_addr;
            end
            chk("pc", 32'(pc), 32'(m_pc));
            chk("halted", 32'(halted), 32'(m_halt));
            exp_rd = 1'b0;
            if (ir_ld) begin
                ir_cnt++;
                m_ins = mem[last_addr];
                if (HALT_EN && m_ins[11:8] == 4'hF) begin
                    m_halt = 1'b1;
                end else begin
                    m_pc = m_pc + 8'd1;
                end
            end
            chk("ins", 32'(ins), 32'(m_ins));
            if (fetch_req) begin
                chk("idle_at_req", 32'(busy), 32'd0);
                if (!m_halt) begin
                    exp_rd   = 1'b1;
                    exp_addr = pc_ld ? pc_in : m_pc;
                end
            end
            if (pc_ld) begin
                m_pc   = pc_in;
                m_halt = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 40) begin
            cyc(1);
            t++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_fetch();
        wait_idle();
        fetch_req = 1'b1;
        cyc(1);
        fetch_req = 1'b0;
    endtask

    task automatic jump(input logic [7:0] a);
        pc_ld = 1'b1;
        pc_in = a;
        cyc(1);
        pc_ld = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {4'h3, 8'(i)};
        end
        mif.mem_valid = 1'b0;
        mif.mem_data  = 12'h000;
        fetch_req = 1'b0;
        pc_ld     = 1'b0;
        pc_in     = 8'h00;

        // 1) reset values and exact latency with a 1-cycle memory
        lat = 1;
        do_reset();
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_ins", 32'(ins), 32'h000);
        chk("rst_ir_ld", 32'(ir_ld), 32'd0);
        chk("rst_mem_rd", 32'(mif.mem_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        fetch_req = 1'b1;
        cyc(1);
        fetch_req = 1'b0;
        chk("t1_rd_n1", 32'(mif.mem_rd), 32'd1);
        chk("t1_addr_n1", 32'(mif.mem_addr), 32'h00);
        cyc(1);
        chk("t1_ir_ld_n2", 32'(ir_ld), 32'd0);
        cyc(1);
        chk("t1_ir_ld_n3", 32'(ir_ld), 32'd1);
        chk("t1_ins_n3", 32'(ins), 32'h300);
        cyc(1);
        chk("t1_busy_n4", 32'(busy), 32'd0);
        chk("t1_pc_n4", 32'(pc), 32'h01);

        // 2) three back-to-back fetches at latency 3
        do_reset();
        lat = 3;
        base = ir_cnt;
        repeat (3) do_fetch();
        wait_idle();
        chk("t2_loads", 32'(ir_cnt - base), 32'd3);
        chk("t2_pc", 32'(pc), 32'h03);
        chk("t2_ins", 32'(ins), 32'h302);

        // 3) PC wrap from FF
        jump(8'hFF);
        chk("t3_pc_ff", 32'(pc), 32'hFF);
        do_fetch();
        wait_idle();
        chk("t3_pc_wrap", 32'(pc), 32'h00);
        chk("t3_ins", 32'(ins), 32'h3FF);

        // 4) jump during WAIT: response dropped, next fetch uses the target
        base = ir_cnt;
        do_fetch();
        cyc(1);
        chk("t4_busy_wait", 32'(busy), 32'd1);
        jump(8'h40);
        wait_idle();
        cyc(3);
        chk("t4_no_load", 32'(ir_cnt - base), 32'd0);
        chk("t4_pc", 32'(pc), 32'h40);
        do_fetch();
        chk("t4_addr", 32'(mif.mem_addr), 32'h40);
        wait_idle();
        chk("t4_ins", 32'(ins), 32'h340);
        chk("t4_pc_next", 32'(pc), 32'h41);

        // 4b) jump in the same cycle the response arrives: straight back to IDLE
        lat = 2;
        base = ir_cnt;
        do_fetch();
        cyc(2);
        jump(8'h50);
        chk("t4b_idle", 32'(busy), 32'd0);
        chk("t4b_pc", 32'(pc), 32'h50);
        chk("t4b_no_load", 32'(ir_cnt - base), 32'd0);

        // 5) jump together with fetch_req, then jump during LOAD
        lat = 1;
        wait_idle();
        pc_ld = 1'b1;
        pc_in = 8'h20;
        fetch_req = 1'b1;
        cyc(1);
        pc_ld = 1'b0;
        fetch_req = 1'b0;
        chk("t5_rd", 32'(mif.mem_rd), 32'd1);
        chk("t5_addr", 32'(mif.mem_addr), 32'h20);
        cyc(2);
        chk("t5_ir_ld", 32'(ir_ld), 32'd1);
        chk("t5_ins", 32'(ins), 32'h320);
        jump(8'h80);
        chk("t5_pc", 32'(pc), 32'h80);
        chk("t5_idle", 32'(busy), 32'd0);

        // 6) HALT opcode at address 5
        mem[5] = 12'hF00;
        jump(8'h05);
        base = ir_cnt;
        do_fetch();
        wait_idle();
        chk("t6_ins", 32'(ins), 32'hF00);
        if (HALT_EN) begin
            chk("t6_halted", 32'(halted), 32'd1);
            chk("t6_pc_hold", 32'(pc), 32'h05);
            fetch_req = 1'b1;
            cyc(3);
            chk("t6_req_ignored", 32'(busy), 32'd0);
            fetch_req = 1'b0;
            chk("t6_one_load", 32'(ir_cnt - base), 32'd1);
            jump(8'h06);
            chk("t6_halt_clr", 32'(halted), 32'd0);
            chk("t6_pc_jump", 32'(pc), 32'h06);
        end else begin
            chk("t6_not_halted", 32'(halted), 32'd0);
            chk("t6_pc_inc", 32'(pc), 32'h06);
        end

        // 7) reset mid-fetch; the late response must be ignored
        lat = 3;
        base = ir_cnt;
        do_fetch();
        cyc(1);
        do_reset();
        chk("t7_pc", 32'(pc), 32'h00);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_ins", 32'(ins), 32'h000);
        cyc(5);
        chk("t7_still_idle", 32'(busy), 32'd0);
        chk("t7_no_load", 32'(ir_cnt - base), 32'd0);

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
